ls_exec_unit: RTL

- Load/store execution stage directly downstream of the LSQ issue register.
- Takes one issued memory op (valid, mode, Px, Addr, tag_ROB) at a time and reads store data from the physical register file.
- Performs the data-memory access over a req/ready + rvalid handshake.
- Broadcasts completion on the ls result bus (Pw, valid, mode, tag_ROB) that the LSQ, RS and ROB snoop, and writes load data back to the register file.

---
 rtl/ls_exec_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ls_exec_unit.sv
// rtl/ls_exec_unit.sv - load/store execution stage: one memory op at a time, result broadcast and load writeback
module ls_exec_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int PREG_W = 5,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_op_in,
    input  logic              mode_in,
    input  logic [PREG_W-1:0] Px_in,
    input  logic [ADDR_W-1:0] Addr_in,
    input  logic [TAG_W-1:0]  tag_ROB_in,
    output logic              freeze_back,
    output logic [PREG_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              valid_Result_ls,
    output logic              mode_ls,
    output logic [PREG_W-1:0] Pw_Result_ls,
    output logic [TAG_W-1:0]  tag_ROB_Result_ls,
    output logic              rf_we,
    output logic [PREG_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [PREG_W-1:0] px_q, px_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              res_valid_q, res_valid_d;
    logic              res_mode_q, res_mode_d;
    logic [PREG_W-1:0] res_pw_q, res_pw_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic              wb_we_q, wb_we_d;
    logic [PREG_W-1:0] wb_waddr_q, wb_waddr_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        px_d        = px_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        wdata_d     = wdata_q;
        res_valid_d = 1'b0;
        res_mode_d  = 1'b0;
        res_pw_d    = '0;
        res_tag_d   = '0;
        wb_we_d     = 1'b0;
        wb_waddr_d  = '0;
        wb_wdata_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (valid_op_in && !flush) begin
                    mode_d  = mode_in;
                    px_d    = Px_in;
                    addr_d  = Addr_in;
                    tag_d   = tag_ROB_in;
                    wdata_d = mode_in ? '0 : rf_rdata;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Once accepted, a flushed request still owes a response that must be drained.
                if (flush) begin
                    if (mem_ready && !mem_rvalid) state_d = S_DRAIN;
                    else                          state_d = S_IDLE;
                end else if (mem_ready) begin
                    state_d = mem_rvalid ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid)  state_d = flush ? S_IDLE : S_RESP;
                else if (flush)  state_d = S_DRAIN;
            end
            S_RESP:  state_d = S_IDLE;
            S_DRAIN: if (mem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_RESP) begin
            res_valid_d = 1'b1;
            res_mode_d  = mode_q;
            res_pw_d    = px_q;
            res_tag_d   = tag_q;
            wb_we_d     = mode_q;
            wb_waddr_d  = mode_q ? px_q : '0;
            wb_wdata_d  = mode_q ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            px_q        <= '0;
            addr_q      <= '0;
            tag_q       <= '0;
            wdata_q     <= '0;
            res_valid_q <= 1'b0;
            res_mode_q  <= 1'b0;
            res_pw_q    <= '0;
            res_tag_q   <= '0;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            px_q        <= px_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            wdata_q     <= wdata_d;
            res_valid_q <= res_valid_d;
            res_mode_q  <= res_mode_d;
            res_pw_q    <= res_pw_d;
            res_tag_q   <= res_tag_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
        end
    end

    assign freeze_back = (state_q != S_IDLE) | valid_op_in;
    assign rf_raddr    = Px_in;
    assign mem_req     = (state_q == S_REQ);
    assign mem_we      = mem_req & ~mode_q;
    assign mem_addr    = mem_req ? addr_q : '0;
    assign mem_wdata   = mem_req ? wdata_q : '0;

    // A flush landing on the RESP cycle kills the broadcast before the snoopers see it.
    assign valid_Result_ls   = res_valid_q & ~flush;
    assign mode_ls           = res_mode_q & ~flush;
    assign Pw_Result_ls      = flush ? '0 : res_pw_q;
    assign tag_ROB_Result_ls = flush ? '0 : res_tag_q;
    assign rf_we             = wb_we_q & ~flush;
    assign rf_waddr          = flush ? '0 : wb_waddr_q;
    assign rf_wdata          = flush ? '0 : wb_wdata_q;

endmodule
